// File: rtl/fetch_gshare_pkg.sv
// Shared types and constants for the gshare fetch stage: fetch_out_t, predecode opcodes,
// default history length and the 2-bit counter training helper.
package fetch_gshare_pkg;

  localparam int FETCH_HIST_BITS = 10;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  // ghr field is sized by the package default; the fetch stage zero-extends/truncates into it
  typedef struct packed {
    logic [31:0]                pc;
    logic [31:0]                instruction;
    logic                       prediction;
    logic                       branch;
    logic                       jump;
    logic [FETCH_HIST_BITS-1:0] ghr;
  } fetch_out_t;

  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_gshare_pht.sv
// Pattern history table of 2-bit saturating counters: one combinational read port,
// one synchronous training port, every counter reset to weak not-taken.
module fetch_gshare_pht
  import fetch_gshare_pkg::*;
#(
  parameter int IDX_BITS = FETCH_HIST_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic [1:0]          rd_ctr_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic                wr_taken_i
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0] ctr_rd [ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
      logic [1:0] ctr_q;
      logic [1:0] ctr_d;
      logic       hit;

      assign hit   = wr_en_i && (wr_idx_i == IDX_BITS'(gi));
      assign ctr_d = hit ? ctr_train(ctr_q, wr_taken_i) : ctr_q;

      always_ff @(posedge clk) begin
        if (!reset) begin
          ctr_q <= CTR_WEAK_NT;
        end else begin
          ctr_q <= ctr_d;
        end
      end

      assign ctr_rd[gi] = ctr_q;
    end
  endgenerate

  // Read sees the pre-update value when training hits the same entry this cycle
  assign rd_ctr_o = ctr_rd[rd_idx_i];

endmodule

// File: rtl/fetch_gshare.sv
// Fetch stage: PC register, speculative global history, gshare prediction and predecode.
// Optional direct-mapped BTB steering next_pc is enabled by defining FETCH_BTB_EN.
module fetch_gshare
  import fetch_gshare_pkg::*;
#(
  parameter int          HIST_BITS   = FETCH_HIST_BITS,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          BTB_ENTRIES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output fetch_out_t           fetch_out,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic [HIST_BITS-1:0] redirect_ghr,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic [HIST_BITS-1:0] upd_ghr,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target
);

  logic [31:0]          pc_q, pc_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]          next_pc;
  logic [6:0]           opcode;
  logic                 is_branch, is_jump, prediction, fire;
  logic [HIST_BITS-1:0] rd_idx, wr_idx;
  logic [1:0]           rd_ctr;
  logic                 unused_bits;

  assign imem_addr = pc_q;
  assign opcode    = imem_rdata[6:0];
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

  assign rd_idx = ghr_q ^ pc_q[HIST_BITS+1:2];
  assign wr_idx = upd_ghr ^ upd_pc[HIST_BITS+1:2];

  fetch_gshare_pht #(
    .IDX_BITS (HIST_BITS)
  ) u_pht (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (rd_idx),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (upd_valid),
    .wr_idx_i   (wr_idx),
    .wr_taken_i (upd_taken)
  );

  assign prediction = (rd_ctr[1] & is_branch) | is_jump;

  // A redirect kills whatever is being presented this cycle
  assign out_valid = reset & ~redirect_valid;
  assign fire      = out_valid & out_ready;

`ifdef FETCH_BTB_EN
  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W     = 32 - BTB_IDX_W - 2;

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q [BTB_ENTRIES];
  logic [BTB_IDX_W-1:0]   btb_rd_idx, btb_wr_idx;
  logic                   btb_hit, btb_wr;

  assign btb_rd_idx = pc_q[BTB_IDX_W+1:2];
  assign btb_wr_idx = upd_pc[BTB_IDX_W+1:2];
  assign btb_wr     = reset & upd_valid & upd_taken;

  always_ff @(posedge clk) begin
    if (!reset) begin
      btb_valid_q <= '0;
    end else if (btb_wr) begin
      btb_valid_q[btb_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag_q[btb_wr_idx] <= upd_pc[31:BTB_IDX_W+2];
      btb_tgt_q[btb_wr_idx] <= upd_target;
    end
  end

  assign btb_hit = btb_valid_q[btb_rd_idx] && (btb_tag_q[btb_rd_idx] == pc_q[31:BTB_IDX_W+2]);
  assign next_pc = (btb_hit && prediction) ? btb_tgt_q[btb_rd_idx] : pc_q + 32'd4;
  assign unused_bits = ^upd_pc[1:0];
`else
  // Without a BTB the back end is responsible for redirecting taken branches
  assign next_pc = pc_q + 32'd4;
  assign unused_bits = ^{upd_target, upd_pc[31:HIST_BITS+2], upd_pc[1:0], BTB_ENTRIES[0]};
`endif

  always_comb begin
    pc_d  = pc_q;
    ghr_d = ghr_q;
    if (redirect_valid) begin
      pc_d  = redirect_pc;
      ghr_d = redirect_ghr;
    end else if (fire) begin
      pc_d = next_pc;
      if (is_branch) begin
        ghr_d = {ghr_q[HIST_BITS-2:0], prediction};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      ghr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ghr_q <= ghr_d;
    end
  end

  always_comb begin
    fetch_out             = '0;
    fetch_out.pc          = pc_q;
    fetch_out.instruction = imem_rdata;
    fetch_out.prediction  = prediction;
    fetch_out.branch      = is_branch;
    fetch_out.jump        = is_jump;
    fetch_out.ghr         = FETCH_HIST_BITS'(ghr_q);
  end

endmodule

// File: tb/tb_fetch_gshare.sv
// Bench for fetch_gshare: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural fetch/predictor model. Honours FETCH_BTB_EN.
module tb_fetch_gshare;
  import fetch_gshare_pkg::*;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam int          HB     = 10;
  localparam int          BTB_N  = 64;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] BEQ    = 32'h00000063;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   imem_addr, imem_rdata;
  logic          out_valid, out_ready;
  fetch_out_t    fo;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [HB-1:0] redirect_ghr;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic [HB-1:0] upd_ghr;
  logic          upd_taken;
  logic [31:0]   upd_target;

  logic [31:0] mem [1024];
  assign imem_rdata = mem[imem_addr[11:2]];

  always #5 clk = ~clk;

  fetch_gshare #(
    .HIST_BITS   (HB),
    .RESET_PC    (RST_PC),
    .BTB_ENTRIES (BTB_N)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fetch_out      (fo),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ghr   (redirect_ghr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_ghr        (upd_ghr),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  int          m_ghr;
  int          m_pht [1024];
  bit          m_bv  [BTB_N];
  logic [31:0] m_bpc [BTB_N];
  logic [31:0] m_btgt[BTB_N];
  bit          m_ok = 0;

  always @(negedge clk) begin
    logic [31:0] instr, npc;
    logic        br, jp, pred, exp_valid;
    int          idx, bi;
    instr = mem[m_pc[11:2]];
    br    = (instr[6:0] == 7'h63);
    jp    = (instr[6:0] == 7'h6F) || (instr[6:0] == 7'h67);
    idx   = (m_ghr ^ int'(m_pc >> 2)) & 1023;
    pred  = (br && m_pht[idx] >= 2) || jp;
    exp_valid = reset && !redirect_valid;
    if (m_ok) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("fo.pc",     fo.pc, m_pc);
        chk("fo.instr",  fo.instruction, instr);
        chk("fo.pred",   {31'd0, fo.prediction}, {31'd0, pred});
        chk("fo.branch", {31'd0, fo.branch}, {31'd0, br});
        chk("fo.jump",   {31'd0, fo.jump}, {31'd0, jp});
        chk("fo.ghr",    {22'd0, fo.ghr}, 32'(m_ghr));
        if (out_ready)
          $display("xfer pc=%h instr=%h br=%0d jp=%0d pred=%0d ghr=%03h", m_pc, instr, br, jp, pred, m_ghr);
      end
    end
    if (!reset) begin
      m_pc  = RST_PC;
      m_ghr = 0;
      foreach (m_pht[i]) m_pht[i] = 1;
      foreach (m_bv[i])  m_bv[i] = 0;
      m_ok  = 1;
    end else if (m_ok) begin
      if (redirect_valid) begin
        m_pc  = redirect_pc;
        m_ghr = int'(redirect_ghr);
      end else if (out_ready) begin
        npc = m_pc + 32'd4;
`ifdef FETCH_BTB_EN
        bi = int'(m_pc >> 2) & (BTB_N - 1);
        if (pred && m_bv[bi] && ((m_bpc[bi] >> 8) == (m_pc >> 8))) npc = m_btgt[bi];
`endif
        if (br) m_ghr = ((m_ghr << 1) | int'(pred)) & 1023;
        m_pc = npc;
      end
      if (upd_valid) begin
        idx = (int'(upd_ghr) ^ int'(upd_pc >> 2)) & 1023;
        if (upd_taken) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
        else           m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
        if (upd_taken) begin
          bi = int'(upd_pc >> 2) & (BTB_N - 1);
          m_bv[bi]   = 1;
          m_bpc[bi]  = upd_pc;
          m_btgt[bi] = upd_target;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc, input logic [HB-1:0] g);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    redirect_ghr   = g;
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [HB-1:0] g, input logic t,
                       input logic [31:0] tgt, input int n);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_ghr    = g;
    upd_taken  = t;
    upd_target = tgt;
    repeat (n) cyc();
    upd_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] w;
    w = $urandom;
    if (w[31:28] == 4'd0) return {20'hFFFFF, w[9:0], 2'b00};
    return {22'd0, w[7:0], 2'b00};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          r;
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r < 4)       w[6:0] = 7'b1100011;
    else if (r == 4) w[6:0] = 7'b1101111;
    else if (r == 5) w[6:0] = 7'b1100111;
    else             w[6:0] = 7'b0010011;
    return w;
  endfunction

  initial begin
    foreach (mem[i]) mem[i] = NOP;
    mem[32'h40 >> 2] = BEQ;
    mem[32'h80 >> 2] = BEQ;
    reset = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; redirect_ghr = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0; upd_target = '0;

    // 1: sequential fetch after reset
    at_neg();
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("seq addr", imem_addr, RST_PC + 32'(4 * i));
      cyc();
    end

    // 2: stall holds pc and snapshot
    redirect(32'h20, '0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("stall addr", imem_addr, 32'h20);
      chk("stall fo.pc", fo.pc, 32'h20);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    at_neg();
    chk("resume addr", imem_addr, 32'h24);

    // 3: counter training at idx 0x10 incl. saturation
    do_reset();
    out_ready = 1'b0;
    redirect(32'h40, '0);
    at_neg();
    chk("pred init", {31'd0, fo.prediction}, 32'd0);
    train(32'h40, '0, 1'b1, 32'h44, 3);
    at_neg();
    chk("pred sat", {31'd0, fo.prediction}, 32'd1);
    train(32'h40, '0, 1'b0, 32'h44, 1);
    at_neg();
    chk("pred 3->2", {31'd0, fo.prediction}, 32'd1);
    train(32'h40, '0, 1'b0, 32'h44, 1);
    at_neg();
    chk("pred 2->1", {31'd0, fo.prediction}, 32'd0);

    // 4: speculative history update on a predicted-taken branch
    train(32'h40, 10'h005, 1'b1, 32'h44, 2);
    redirect(32'h40, 10'h005);
    at_neg();
    chk("t4 pred", {31'd0, fo.prediction}, 32'd1);
    chk("t4 ghr", {22'd0, fo.ghr}, 32'h005);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    at_neg();
    chk("t4 next addr", imem_addr, 32'h44);
    chk("t4 next ghr", {22'd0, fo.ghr}, 32'h00B);

    // 5: redirect beats a pending fire
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h200; redirect_ghr = 10'h3FF;
    at_neg();
    chk("t5 out_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    at_neg();
    chk("t5 addr", imem_addr, 32'h200);
    chk("t5 ghr", {22'd0, fo.ghr}, 32'h3FF);

    // PC wraps past the top of the address space
    redirect(32'hFFFF_FFFC, '0);
    out_ready = 1'b1;
    cyc();
    at_neg();
    chk("wrap addr", imem_addr, 32'h0);

    // 6: BTB steering (or sequential without it)
    do_reset();
    out_ready = 1'b0;
    train(32'h80, '0, 1'b1, 32'h400, 2);
    redirect(32'h80, '0);
    at_neg();
    chk("t6 pred", {31'd0, fo.prediction}, 32'd1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    at_neg();
`ifdef FETCH_BTB_EN
    chk("t6 next addr", imem_addr, 32'h400);
`else
    chk("t6 next addr", imem_addr, 32'h84);
`endif

    // randomized run with a mid-stream reset
    foreach (mem[i]) mem[i] = rand_instr();
    cyc();
    for (int c = 0; c < 3000; c++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = rand_pc();
      redirect_ghr   = HB'($urandom);
      upd_valid      = ($urandom_range(0, 2) == 0);
      upd_pc         = rand_pc();
      upd_ghr        = ($urandom_range(0, 1) == 0) ? HB'(m_ghr) : HB'($urandom);
      upd_taken      = 1'($urandom);
      upd_target     = rand_pc();
      reset          = !(c >= 1500 && c < 1502);
      cyc();
    end
    redirect_valid = 1'b0;
    upd_valid = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
